serial_ones_tx: RTL and testbench



---
 rtl/serial_ones_tx.sv | 110 +++++++++++
 tb/tb_serial_ones_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ones_tx.sv
// LSB-first serializer for the ones-counting detector, with a cycle-accurate
// mirror of the detector's mod-4 state so y can be predicted locally.
module serial_ones_tx #(
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              cnt_clr,
  output logic              x,
  output logic              busy,
  output logic              done,
  output logic [1:0]        ones_mod4,
  output logic              y_pred
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [GAP_W-1:0] GAP_ONE  = 1;
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_per;
  logic [IDX_W-1:0]  r_idx;
  logic [GAP_W-1:0]  r_gap;
  logic              r_done;
  logic [1:0]        r_ones;

  logic              w_accept;
  logic              w_bit_end;
  logic              w_word_end;
  logic [DATA_W-1:0] w_shift_nxt;

  assign tx_ready    = (r_state == IDLE) & ~rst;
  assign w_accept    = tx_valid & tx_ready;
  assign w_bit_end   = (r_state == SEND) && (r_per == r_div);
  assign w_word_end  = w_bit_end && (r_idx == LAST_IDX);
  assign w_shift_nxt = r_shift >> 1;

  // Bit 0 of the shift register is the line itself; zeros shift in behind the
  // word, so the line is already low once the last bit has been shifted out.
  assign x         = r_shift[0];
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ones_mod4 = r_ones;
  assign y_pred    = (r_ones == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_word_end) w_state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
      GAP:     if (r_gap == LAST_GAP) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_div   <= '0;
      r_per   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
      r_ones  <= 2'd0;
    end else begin
      // Clear beats a concurrent x=1, matching the receiver's behaviour.
      r_ones <= cnt_clr ? 2'd0 : r_ones + {1'b0, r_shift[0]};
      r_done <= w_word_end;
      r_gap  <= (r_state == GAP) ? r_gap + GAP_ONE : '0;
      if (w_accept) begin
        r_shift <= tx_data;
        r_div   <= div;
        r_per   <= '0;
        r_idx   <= '0;
      end else if (r_state == SEND) begin
        if (w_bit_end) begin
          r_per   <= '0;
          r_shift <= w_shift_nxt;
          r_idx   <= r_idx + IDX_ONE;
        end else begin
          r_per <= r_per + DIV_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_ones_tx.sv
// Bench for serial_ones_tx: directed word table, hand-written corner sequences,
// and random traffic against a queue-based model of the line and detector.
module tb_serial_ones_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div, tx_data;
  logic       tx_valid, cnt_clr;
  logic       tx_ready, x, busy, done, y_pred;
  logic [1:0] ones_mod4;

  logic [7:0] div0_i, data0;
  logic       valid0, clr0;
  logic       ready0, x0, busy0, done0, y0;
  logic [1:0] ones0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_ones_tx #(.DATA_W(8), .DIV_W(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .div(div), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cnt_clr(cnt_clr), .x(x), .busy(busy), .done(done),
    .ones_mod4(ones_mod4), .y_pred(y_pred)
  );

  serial_ones_tx #(.DATA_W(8), .DIV_W(8), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .div(div0_i), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .cnt_clr(clr0), .x(x0), .busy(busy0), .done(done0),
    .ones_mod4(ones0), .y_pred(y0)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] dv;
    int         exp_high;
    int         exp_ones;
    int         exp_done;
    int         exp_ready;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0; cnt_clr = 1'b0; div = '0; tx_data = '0;
    valid0 = 1'b0; clr0 = 1'b0; div0_i = '0; data0 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Leaves the bench in cycle 1, the first cycle carrying bit 0.
  task automatic start_word(input logic [7:0] d, input logic [7:0] dv);
    do_reset();
    chk("ready_before_accept", tx_ready, 1);
    tx_data = d; div = dv; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] w;
    int         hi, dcnt, dfirst, k;
    bit         q[$];
    int         m_ones, done_at;
    logic       ex;
    logic [7:0] rd, rdv;
    logic       rv, rc;

    vecs[0] = '{8'hB5, 8'd0,   5,   1, 9,    11};
    vecs[1] = '{8'h01, 8'd2,   3,   3, 25,   27};
    vecs[2] = '{8'hFF, 8'd0,   8,   0, 9,    11};
    vecs[3] = '{8'h00, 8'd1,   0,   0, 17,   19};
    vecs[4] = '{8'h0A, 8'd0,   2,   2, 9,    11};
    vecs[5] = '{8'hB5, 8'd2,   15,  3, 25,   27};
    vecs[6] = '{8'h80, 8'd255, 256, 0, 2049, 2051};
    vecs[7] = '{8'h7F, 8'd1,   14,  2, 17,   19};

    // Table of single words: ones seen, final mirror, done and ready timing.
    for (int v = 0; v < 8; v++) begin
      start_word(vecs[v].data, vecs[v].dv);
      k = 1; hi = 0; dcnt = 0; dfirst = -1;
      while (!tx_ready && k < 3000) begin
        if (x) hi++;
        if (done) begin
          dcnt++;
          if (dfirst < 0) dfirst = k;
        end
        tick();
        k++;
      end
      chk("vec_high_cycles", hi, vecs[v].exp_high);
      chk("vec_ones_final", ones_mod4, vecs[v].exp_ones);
      chk("vec_y_pred_final", y_pred, vecs[v].exp_ones == 3);
      chk("vec_done_cycle", dfirst, vecs[v].exp_done);
      chk("vec_done_count", dcnt, 1);
      chk("vec_ready_cycle", k, vecs[v].exp_ready);
    end

    // Reset asserted mid-word.
    start_word(8'hFF, 8'd0);
    tick(); tick(); tick();
    chk("pre_reset_ones", ones_mod4, 3);
    rst = 1'b1;
    #1;
    chk("rst_async_x", x, 0);
    chk("rst_async_ones", ones_mod4, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_x", x, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ones", ones_mod4, 0);
      chk("rst_ready", tx_ready, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_busy", busy, 0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || x) dcnt++;
      tick();
    end
    chk("post_rst_no_done_no_x", dcnt, 0);

    // 0xB5 at one clock per bit: exact line, y_pred, done and ready timing.
    w = 8'hB5;
    start_word(w, 8'd0);
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8) chk("b5_x", x, w[c-1]);
      else        chk("b5_x_idle", x, 0);
      chk("b5_y_pred", y_pred, c == 6);
      chk("b5_done", done, c == 9);
      chk("b5_ready", tx_ready, c == 11);
      if (c == 9) chk("b5_ones_final", ones_mod4, 1);
      tick();
    end

    // Clear colliding with x=1 while the mirror sits at 2.
    start_word(8'hB5, 8'd0);
    tick(); tick(); tick(); tick();
    chk("clr_pre_x", x, 1);
    chk("clr_pre_ones", ones_mod4, 2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", ones_mod4, 0);
    tick();
    chk("clr_after", ones_mod4, 1);

    // Back-to-back words on the zero-gap instance with valid held.
    do_reset();
    data0 = 8'hFF; div0_i = 8'd0; valid0 = 1'b1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      chk("b2b_x", x0, (c != 9) && (c != 18));
      chk("b2b_done", done0, (c == 9) || (c == 18));
      if (c == 9 || c == 18) chk("b2b_ones_wrap", ones0, 0);
      if (c == 9) chk("b2b_ready_on_done", ready0, 1);
      if (c == 10) valid0 = 1'b0;
      tick();
    end

    // Input changes and valid pulses during SEND must not disturb the word.
    w = 8'hA5;
    start_word(w, 8'd0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 8) chk("hs_x", x, w[c-1]);
      chk("hs_done", done, c == 9);
      chk("hs_busy", busy, c <= 10);
      chk("hs_ready", tx_ready, c >= 11);
      if (c == 3) begin tx_data = 8'hFF; div = 8'd5; tx_valid = 1'b1; end
      if (c == 6) tx_valid = 1'b0;
      tick();
    end

    // Random traffic against a queue model of per-cycle line values.
    do_reset();
    m_ones = 0; done_at = -1;
    q.delete();
    for (int c = 0; c < 1200; c++) begin
      ex = (q.size() != 0) ? q[0] : 1'b0;
      chk("rnd_x", x, ex);
      chk("rnd_busy", busy, q.size() != 0);
      chk("rnd_ready", tx_ready, q.size() == 0);
      chk("rnd_done", done, c == done_at);
      chk("rnd_ones", ones_mod4, m_ones);
      chk("rnd_y_pred", y_pred, m_ones == 3);
      rv  = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      rdv = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 2));
      rc  = ($urandom_range(0, 9) == 0);
      tx_valid = rv; tx_data = rd; div = rdv; cnt_clr = rc;
      m_ones = rc ? 0 : (m_ones + int'(ex)) % 4;
      if (q.size() != 0) void'(q.pop_front());
      else if (rv) begin
        for (int b = 0; b < 8; b++)
          for (int r = 0; r <= int'(rdv); r++) q.push_back(rd[b]);
        for (int g = 0; g < 2; g++) q.push_back(1'b0);
        done_at = c + 1 + 8 * (int'(rdv) + 1);
      end
      tick();
    end
    tx_valid = 1'b0; cnt_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
